enet_nios_enet_bus_ctrl: RTL
============================

// Module: enet_nios_enet_bus_ctrl
// PURPOSE
//  Wait-state bus controller between the Nios Avalon slave port and the external Ethernet
//  controller chip. Consumes the decoded chip-select produced by the cascade-chain address
//  comparator stage and turns each Avalon read/write into a timed async cycle
//  (setup/strobe/hold, ARDY-extended) with Avalon waitrequest back-pressure.
// PARAMETERS
//  ADDR_W      4    external register address width
//  DATA_W      16   data bus width
//  SETUP_CYC   1    cycles cs_n low before strobe (0 = skip SETUP)
//  STROBE_CYC  3    minimum rd_n/wr_n low cycles (>=1)
//  HOLD_CYC    1    cycles cs_n low after strobe release (0 = skip HOLD)
//  ARDY_TMO    255  max extra strobe cycles waiting for enet_ardy (>=1)
// PORTS
//  clk             in   1       system clock, all logic rising-edge
//  reset           in   1       synchronous, active-high
//  av_chipselect   in   1       decoded match from cascade-chain comparator
//  av_read         in   1       Avalon read request
//  av_write        in   1       Avalon write request
//  av_address      in   ADDR_W  register address
//  av_writedata    in   DATA_W  write data
//  av_readdata     out  DATA_W  read data, valid when waitrequest low on a read
//  av_waitrequest  out  1       stall to Nios
//  enet_addr       out  ADDR_W  external address
//  enet_dout       out  DATA_W  external write data
//  enet_doe        out  1       data bus output enable
//  enet_din        in   DATA_W  external read data
//  enet_cs_n       out  1       chip select, active-low
//  enet_rd_n       out  1       read strobe, active-low
//  enet_wr_n       out  1       write strobe, active-low
//  enet_ardy       in   1       external ready, high = ready
//  tmo_flag        out  1       sticky ARDY timeout indication
//  tmo_clr         in   1       clears tmo_flag
// BEHAVIOUR
//  Reset: state IDLE; cs_n/rd_n/wr_n=1, doe=0, enet_addr/dout=0, av_readdata=0, tmo_flag=0.
//  Reset mid-cycle aborts: strobes/cs_n deassert at the next edge, no readdata update.
//  req = av_chipselect & (av_read|av_write); read wins if both high (write ignored).
//  av_waitrequest = reset | (req & state!=DONE) (combinational).
//  FSM: IDLE -> SETUP -> STROBE -> WAIT_RDY -> HOLD -> DONE -> IDLE.
//   IDLE: req sampled -> latch addr/data/dir; next SETUP (or STROBE if SETUP_CYC=0).
//   SETUP: cs_n=0, addr driven, doe=1 on write; SETUP_CYC cycles.
//   STROBE: rd_n or wr_n=0 for STROBE_CYC cycles; exit to HOLD if enet_ardy=1 on last
//    cycle, else WAIT_RDY.
//   WAIT_RDY: strobe held low; exit when enet_ardy=1 or ARDY_TMO cycles elapsed.
//   Read data captured from enet_din on the final strobe cycle (strobe still low).
//   Timeout: av_readdata captures {DATA_W{1'b1}}, tmo_flag set; cycle completes normally.
//   HOLD: strobe high, cs_n=0, doe/addr/dout held; HOLD_CYC cycles (skipped if 0).
//   DONE: cs_n=1, doe=0; waitrequest low one cycle; next IDLE unconditionally.
//  Request dropped by master mid-cycle: external cycle still completes (no truncation).
//  Back-to-back: new req seen in IDLE starts next cycle; min 1 idle cycle with cs_n=1.
//  Default latency: waitrequest high 1+1+3+1 = 6 cycles, low on 7th (ardy high).
//  Counters saturate-free: reload on state entry, sized clog2 of max param +1.
//  tmo_clr and a new timeout in the same cycle: set wins.
// TESTING
//  Read addr 4'h3, enet_din=16'hA55A, ardy=1 -> rd_n low 3 cycles, readdata=A55A, wait 6 cyc.
//  Write addr 4'hC data 16'h1234 -> cs_n 5 cyc low, wr_n 3 cyc low, doe high whole cs_n window.
//  Read with ardy low 10 extra cycles -> rd_n low 13 cycles, waitrequest high 16 cycles.
//  ardy stuck low, ARDY_TMO=255 -> readdata=FFFF, tmo_flag=1; tmo_clr pulse -> tmo_flag=0.
//  av_read&av_write together -> read cycle only, wr_n never low; SETUP_CYC=HOLD_CYC=0 -> 4-cycle wait.
//  reset asserted during STROBE -> next edge cs_n=rd_n=1, state IDLE, readdata unchanged (0).

Source files
------------

// File: rtl/enet_nios_enet_bus_ctrl.sv
// Avalon-slave to external Ethernet chip bus controller: stretches each Avalon access into a
// timed async cycle (setup / strobe / ARDY wait / hold) and stalls the master with waitrequest.
module enet_nios_enet_bus_ctrl #(
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 3,
  parameter int HOLD_CYC   = 1,
  parameter int ARDY_TMO   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              av_chipselect,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [ADDR_W-1:0] av_address,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] enet_addr,
  output logic [DATA_W-1:0] enet_dout,
  output logic              enet_doe,
  input  logic [DATA_W-1:0] enet_din,
  output logic              enet_cs_n,
  output logic              enet_rd_n,
  output logic              enet_wr_n,
  input  logic              enet_ardy,
  output logic              tmo_flag,
  input  logic              tmo_clr
);

  localparam int M1   = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int M2   = (HOLD_CYC > ARDY_TMO) ? HOLD_CYC : ARDY_TMO;
  localparam int MAXP = (M1 > M2) ? M1 : M2;
  localparam int CW   = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_RDY, HOLD, DONE} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                is_rd_q, is_rd_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                doe_q, doe_d;
  logic                cs_n_q, cs_n_d;
  logic                rd_n_q, rd_n_d;
  logic                wr_n_q, wr_n_d;
  logic                tmo_q, tmo_d;
  logic                req, fin, strobe_on;
  logic [DATA_W-1:0]   fin_val;

  assign req            = av_chipselect & (av_read | av_write);
  assign av_waitrequest = reset | (req & (state_q != DONE));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    dout_d    = dout_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    fin       = 1'b0;
    fin_val   = enet_din;
    strobe_on = 1'b0;
    if (tmo_clr) tmo_d = 1'b0;

    case (state_q)
      IDLE: if (req) begin
        is_rd_d = av_read;
        addr_d  = av_address;
        if (!av_read) dout_d = av_writedata;
        state_d = (SETUP_CYC > 0) ? SETUP : STROBE;
      end
      SETUP: if (cnt_q == '0) state_d = STROBE;
             else cnt_d = cnt_q - 1'b1;
      STROBE: if (cnt_q == '0) begin
        if (enet_ardy) fin = 1'b1;
        else state_d = WAIT_RDY;
      end else cnt_d = cnt_q - 1'b1;
      WAIT_RDY: if (enet_ardy) fin = 1'b1;
      else if (cnt_q == '0) begin
        // timeout still completes the cycle, but returns all-ones and flags it
        fin     = 1'b1;
        fin_val = '1;
        tmo_d   = 1'b1;
      end else cnt_d = cnt_q - 1'b1;
      HOLD: if (cnt_q == '0) state_d = DONE;
            else cnt_d = cnt_q - 1'b1;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (fin) begin
      state_d = (HOLD_CYC > 0) ? HOLD : DONE;
      if (is_rd_q) rdata_d = fin_val;
    end

    if (state_d != state_q) begin
      case (state_d)
        SETUP:    cnt_d = CW'(SETUP_CYC - 1);
        STROBE:   cnt_d = CW'(STROBE_CYC - 1);
        WAIT_RDY: cnt_d = CW'(ARDY_TMO - 1);
        HOLD:     cnt_d = CW'(HOLD_CYC - 1);
        default:  cnt_d = '0;
      endcase
    end

    // pins are registered from the next state so they line up with the state itself
    strobe_on = (state_d == STROBE) || (state_d == WAIT_RDY);
    cs_n_d    = !((state_d == SETUP) || strobe_on || (state_d == HOLD));
    rd_n_d    = !(strobe_on & is_rd_d);
    wr_n_d    = !(strobe_on & !is_rd_d);
    doe_d     = !cs_n_d & !is_rd_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      doe_q   <= 1'b0;
      cs_n_q  <= 1'b1;
      rd_n_q  <= 1'b1;
      wr_n_q  <= 1'b1;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      doe_q   <= doe_d;
      cs_n_q  <= cs_n_d;
      rd_n_q  <= rd_n_d;
      wr_n_q  <= wr_n_d;
      tmo_q   <= tmo_d;
    end
  end

  assign av_readdata = rdata_q;
  assign enet_addr   = addr_q;
  assign enet_dout   = dout_q;
  assign enet_doe    = doe_q;
  assign enet_cs_n   = cs_n_q;
  assign enet_rd_n   = rd_n_q;
  assign enet_wr_n   = wr_n_q;
  assign tmo_flag    = tmo_q;

endmodule
